tlb_mmu: RTL and testbench
==========================

// Module: tlb_mmu
// PURPOSE
//  Joint TLB feeding and consuming CP0 TLB state: stores TLB_LINE_NUM entries, executes
//  tlbp/tlbr/tlbwi/tlbwr from EntryHi/Lo0/Lo1/PageMask/Index/Random, and translates
//  instruction/data VAs. Outputs refill/invalid/modify flags and entry_*_in/index_in to CP0.
// PARAMETERS
//  TLB_LINE_NUM  16  entry count, power of 2; IW = $clog2(TLB_LINE_NUM)
// PORTS
//  clk               in   1   clock
//  rst               in   1   synchronous reset, active-high
//  stallF / stallM   in   1   hold inst result reg / block TLB writes
//  inst_vaddr        in   32  fetch VA, sampled at clk edge
//  data_vaddr        in   32  load/store VA, sampled at clk edge
//  data_store        in   1   access sampled with data_vaddr is a store
//  inst_paddr        out  32  registered PA for inst_vaddr
//  data_paddr        out  32  registered PA for data_vaddr
//  inst_tlb_refill / inst_tlb_invalid                   out 1  registered inst flags
//  data_tlb_refill / data_tlb_invalid / data_tlb_modify out 1  registered data flags
//  tlb_typeE         in   4   {tlbwr,tlbwi,tlbr,tlbp}, one-hot or zero
//  entry_hi_W / page_mask_W / entry_lo0_W / entry_lo1_W / index_W / random_o  in 32  CP0 state
//  entry_hi_in / page_mask_in / entry_lo0_in / entry_lo1_in / index_in        out 32 to CP0
// BEHAVIOUR
//  - Entry: VPN2[31:13], ASID[7:0], MASK[24:13], G, PFN0/C0/D0/V0, PFN1/C1/D1/V1.
//  - Match(e,va,asid): (va[31:13]&~MASK)==(VPN2&~MASK) && (G || ASID==asid); asid=entry_hi_W[7:0].
//    Supported MASK: 12'h000 (4KB, odd sel va[12]) or 12'h003 (16KB, odd sel va[14]).
//  - Unmapped: va[31:30]==2'b10 -> pa={3'b000,va[28:0]}, flags 0. Else mapped.
//  - Mapped: no match -> refill; match & !V -> invalid; data store & V & !D -> modify
//    (data only). Else pa={PFN[19:0],va[11:0]}; 16KB: pa[13:12]=va[13:12].
//    Multiple matches: lowest index wins.
//  - Latency: lookups are 1 cycle; VA sampled at edge N, pa/flags valid through cycle N+1.
//    stallF=1 holds inst result regs; data regs always update.
//  - tlbp (comb.): index_in[31]=~hit; index_in[IW-1:0]=hit index, 0 on miss; other bits 0.
//    VA=entry_hi_W[31:13].
//  - tlbr (comb.): read entry index_W[IW-1:0]. entry_hi_in={VPN2,5'b0,ASID},
//    page_mask_in={7'b0,MASK,13'b0}, entry_lo*_in={6'b0,PFN,C,D,V,G}.
//    G is read back in both lo regs.
//  - tlbwi/tlbwr: write at edge when ~stallM. Target is index_W[IW-1:0] / random_o[IW-1:0].
//    G = entry_lo0_W[0] & entry_lo1_W[0]; VPN2 stored & ~MASK.
//  - Write in cycle N is seen only by lookups sampled at edge N+1 or later.
//    Same-cycle tlbp/tlbr read pre-write contents.
//  - tlb_typeE==0 or stallM: array unchanged. Illegal multi-hot tlb_typeE: priority tlbwr>tlbwi.
//  - Reset: all paddr/flag outputs 0; entry_*_in/index_in track comb. inputs.
//    A reset during a pending write drops the write.
// CONFIGURATION
//  TLB_RESET_CLEAR_EN defined: reset clears every entry (V0=V1=G=0, VPN2=0, ASID=0, MASK=0).
//    All mapped lookups after reset -> refill.
//  Undefined: entries keep prior contents across reset (no reset on array, smaller area).
//    Software must init the TLB.
// TESTING
//  1 tlbwi idx3 VPN2=0x00400>>1,ASID=5,lo0 PFN=0x12 V=1 D=1; data lw VA=0x00400010,ASID=5
//    -> next cycle data_paddr=0x00012010, no flags.
//  2 Same entry, ASID=6, G=0 -> data_tlb_refill=1. Rewrite with both lo G=1 -> hit.
//  3 lo1 V=0, VA=0x00401000 -> invalid. Store with lo0 D=0 -> data_tlb_modify=1.
//  4 tlbp entry_hi_W=0x00400005 -> index_in=0x3. No match -> index_in=0x80000000.
//  5 tlbr index_W=3 -> entry_hi_in=0x00400005, entry_lo0_in PFN 0x12 with G bit.
//    Write+lookup same edge sees old contents.
//  6 inst_vaddr=0xBFC00000 -> inst_paddr=0x1FC00000, no flags.
//    stallF=1 holds inst result while inst_vaddr changes.

Source files
------------

// File: rtl/tlb_mmu.sv
// tlb_mmu: joint TLB with CP0 tlbp/tlbr/tlbwi/tlbwr support and 1-cycle inst/data translation.
// Build option: define TLB_RESET_CLEAR_EN to clear every entry on reset.
module tlb_mmu #(
  parameter int TLB_LINE_NUM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallM,
  input  logic [31:0] inst_vaddr,
  input  logic [31:0] data_vaddr,
  input  logic        data_store,
  output logic [31:0] inst_paddr,
  output logic [31:0] data_paddr,
  output logic        inst_tlb_refill,
  output logic        inst_tlb_invalid,
  output logic        data_tlb_refill,
  output logic        data_tlb_invalid,
  output logic        data_tlb_modify,
  input  logic [3:0]  tlb_typeE,
  input  logic [31:0] entry_hi_W,
  input  logic [31:0] page_mask_W,
  input  logic [31:0] entry_lo0_W,
  input  logic [31:0] entry_lo1_W,
  input  logic [31:0] index_W,
  input  logic [31:0] random_o,
  output logic [31:0] entry_hi_in,
  output logic [31:0] page_mask_in,
  output logic [31:0] entry_lo0_in,
  output logic [31:0] entry_lo1_in,
  output logic [31:0] index_in
);
  localparam int IW = $clog2(TLB_LINE_NUM);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [11:0] mask;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] pa;
    logic        refill;
    logic        invalid;
    logic        modify;
  } xlat_t;

  function automatic logic entry_match(input tlb_entry_t e, input logic [18:0] vpn2,
                                       input logic [7:0] asid);
    logic [18:0] keep;
    keep = ~{7'b0, e.mask};
    return ((vpn2 & keep) == (e.vpn2 & keep)) && (e.g || (e.asid == asid));
  endfunction

  function automatic xlat_t translate(input tlb_entry_t e, input logic hit,
                                      input logic [31:0] va, input logic is_store);
    xlat_t       r;
    logic        big;
    logic        odd;
    logic        v;
    logic        d;
    logic [19:0] pfn;
    r   = '0;
    big = (e.mask == 12'h003);
    odd = big ? va[14] : va[12];
    pfn = odd ? e.pfn1 : e.pfn0;
    v   = odd ? e.v1 : e.v0;
    d   = odd ? e.d1 : e.d0;
    if (va[31:30] == 2'b10) r.pa = {3'b000, va[28:0]};
    else if (!hit)          r.refill = 1'b1;
    else if (!v)            r.invalid = 1'b1;
    else if (is_store && !d) r.modify = 1'b1;
    else begin
      r.pa = {pfn, va[11:0]};
      // 16KB pages take two more offset bits from the VA.
      if (big) r.pa[13:12] = va[13:12];
    end
    return r;
  endfunction

  tlb_entry_t     tlb_q [TLB_LINE_NUM];
  logic [7:0]     asid;
  logic           inst_hit, data_hit, probe_hit;
  logic [IW-1:0]  inst_idx, data_idx, probe_idx;

  assign asid = entry_hi_W[7:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    inst_hit  = 1'b0;
    data_hit  = 1'b0;
    probe_hit = 1'b0;
    inst_idx  = '0;
    data_idx  = '0;
    probe_idx = '0;
    // Downward scan: the lowest matching index is the last one written.
    for (int i = TLB_LINE_NUM - 1; i >= 0; i--) begin
      if (entry_match(tlb_q[i], inst_vaddr[31:13], asid)) begin
        inst_hit = 1'b1;
        inst_idx = IW'(i);
      end
      if (entry_match(tlb_q[i], data_vaddr[31:13], asid)) begin
        data_hit = 1'b1;
        data_idx = IW'(i);
      end
      if (entry_match(tlb_q[i], entry_hi_W[31:13], asid)) begin
        probe_hit = 1'b1;
        probe_idx = IW'(i);
      end
    end
  end

  xlat_t inst_res_d, inst_res_q, data_res_d, data_res_q;

  assign inst_res_d = stallF ? inst_res_q
                             : translate(tlb_q[inst_idx], inst_hit, inst_vaddr, 1'b0);
  assign data_res_d = translate(tlb_q[data_idx], data_hit, data_vaddr, data_store);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_res_q <= '0;
      data_res_q <= '0;
    end else begin
      inst_res_q <= inst_res_d;
      data_res_q <= data_res_d;
    end
  end

  assign inst_paddr       = inst_res_q.pa;
  assign inst_tlb_refill  = inst_res_q.refill;
  assign inst_tlb_invalid = inst_res_q.invalid;
  assign data_paddr       = data_res_q.pa;
  assign data_tlb_refill  = data_res_q.refill;
  assign data_tlb_invalid = data_res_q.invalid;
  assign data_tlb_modify  = data_res_q.modify;

  // tlbwr wins over tlbwi when both are (illegally) requested.
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [11:0]   wr_mask;
  tlb_entry_t    wr_entry;

  assign wr_en   = ~stallM & (tlb_typeE[3] | tlb_typeE[2]);
  assign wr_idx  = tlb_typeE[3] ? random_o[IW-1:0] : index_W[IW-1:0];
  assign wr_mask = page_mask_W[24:13];

  always_comb begin
    wr_entry      = '0;
    wr_entry.vpn2 = entry_hi_W[31:13] & ~{7'b0, wr_mask};
    wr_entry.asid = entry_hi_W[7:0];
    wr_entry.mask = wr_mask;
    wr_entry.g    = entry_lo0_W[0] & entry_lo1_W[0];
    wr_entry.pfn0 = entry_lo0_W[25:6];
    wr_entry.c0   = entry_lo0_W[5:3];
    wr_entry.d0   = entry_lo0_W[2];
    wr_entry.v0   = entry_lo0_W[1];
    wr_entry.pfn1 = entry_lo1_W[25:6];
    wr_entry.c1   = entry_lo1_W[5:3];
    wr_entry.d1   = entry_lo1_W[2];
    wr_entry.v1   = entry_lo1_W[1];
  end

  // NOTE: the entry array is a memory and is only reset when the clear option is built in;
  // without it, software initialises the TLB and a reset merely drops an in-flight write.
  always_ff @(posedge clk) begin
`ifdef TLB_RESET_CLEAR_EN
    if (rst) begin
      for (int i = 0; i < TLB_LINE_NUM; i++) tlb_q[i] <= '0;
    end else if (wr_en) begin
      tlb_q[wr_idx] <= wr_entry;
    end
`else
    if (!rst && wr_en) tlb_q[wr_idx] <= wr_entry;
`endif
  end

  tlb_entry_t rd;
  assign rd           = tlb_q[index_W[IW-1:0]];
  assign entry_hi_in  = {rd.vpn2, 5'b0, rd.asid};
  assign page_mask_in = {7'b0, rd.mask, 13'b0};
  assign entry_lo0_in = {6'b0, rd.pfn0, rd.c0, rd.d0, rd.v0, rd.g};
  assign entry_lo1_in = {6'b0, rd.pfn1, rd.c1, rd.d1, rd.v1, rd.g};
  assign index_in     = {~probe_hit, {(31 - IW){1'b0}}, probe_idx};

  logic unused_bits;
  assign unused_bits = ^{entry_hi_W[12:8], page_mask_W[31:25], page_mask_W[12:0],
                         entry_lo0_W[31:26], entry_lo1_W[31:26], index_W[31:IW],
                         random_o[31:IW], tlb_typeE[1:0]};
endmodule

// File: tb/tb_tlb_mmu.sv
// Self-checking bench for tlb_mmu: directed vector table, hand sequences, and random
// traffic compared against a page-arithmetic model of the TLB.
module tb_tlb_mmu;
  logic        clk = 1'b0;
  logic        rst, stallF, stallM, data_store;
  logic [31:0] inst_vaddr, data_vaddr, inst_paddr, data_paddr;
  logic        inst_tlb_refill, inst_tlb_invalid;
  logic        data_tlb_refill, data_tlb_invalid, data_tlb_modify;
  logic [3:0]  tlb_typeE;
  logic [31:0] entry_hi_W, page_mask_W, entry_lo0_W, entry_lo1_W, index_W, random_o;
  logic [31:0] entry_hi_in, page_mask_in, entry_lo0_in, entry_lo1_in, index_in;

  tlb_mmu #(.TLB_LINE_NUM(16)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallM(stallM),
    .inst_vaddr(inst_vaddr), .data_vaddr(data_vaddr), .data_store(data_store),
    .inst_paddr(inst_paddr), .data_paddr(data_paddr),
    .inst_tlb_refill(inst_tlb_refill), .inst_tlb_invalid(inst_tlb_invalid),
    .data_tlb_refill(data_tlb_refill), .data_tlb_invalid(data_tlb_invalid),
    .data_tlb_modify(data_tlb_modify), .tlb_typeE(tlb_typeE),
    .entry_hi_W(entry_hi_W), .page_mask_W(page_mask_W), .entry_lo0_W(entry_lo0_W),
    .entry_lo1_W(entry_lo1_W), .index_W(index_W), .random_o(random_o),
    .entry_hi_in(entry_hi_in), .page_mask_in(page_mask_in), .entry_lo0_in(entry_lo0_in),
    .entry_lo1_in(entry_lo1_in), .index_in(index_in)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] T_NONE = 4'b0000, T_P = 4'b0001, T_R = 4'b0010,
                         T_WI = 4'b0100, T_WR = 4'b1000;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: each entry is an aligned VA region of two pages.
  logic [31:0] m_base [16];
  logic [7:0]  m_asid [16];
  logic        m_big  [16];
  logic        m_g    [16];
  logic [31:0] m_lo0  [16];
  logic [31:0] m_lo1  [16];

  function automatic int model_find(input logic [31:0] va, input logic [7:0] asid);
    int unsigned span;
    for (int i = 0; i < 16; i++) begin
      span = m_big[i] ? 32768 : 8192;
      if ((va - va % span) == m_base[i] && (m_g[i] || m_asid[i] == asid)) return i;
    end
    return -1;
  endfunction

  function automatic void model_xlat(input logic [31:0] va, input logic [7:0] asid,
                                     input logic st, output logic [31:0] pa,
                                     output logic [2:0] fl);
    int          hit;
    int unsigned pb;
    logic [31:0] lo;
    pa = 0;
    fl = 3'b000;
    if (va >= 32'h8000_0000 && va < 32'hC000_0000) begin
      pa = va % 32'h2000_0000;
      return;
    end
    hit = model_find(va, asid);
    if (hit < 0) begin
      fl = 3'b100;
      return;
    end
    pb = m_big[hit] ? 16384 : 4096;
    lo = ((va / pb) % 2 == 1) ? m_lo1[hit] : m_lo0[hit];
    if (((lo >> 1) & 1) == 0) fl = 3'b010;
    else if (st && ((lo >> 2) & 1) == 0) fl = 3'b001;
    else begin
      pa = ((lo >> 6) & 32'hF_FFFF) * 4096;
      pa = pa - pa % pb + va % pb;
    end
  endfunction

  function automatic void model_write(input int i, input logic [31:0] eh, input logic [31:0] pm,
                                      input logic [31:0] lo0, input logic [31:0] lo1);
    int unsigned span;
    m_big[i]  = (pm == 32'h6000);
    span      = m_big[i] ? 32768 : 8192;
    m_base[i] = eh - eh % span;
    m_asid[i] = eh[7:0];
    m_g[i]    = lo0[0] & lo1[0];
    m_lo0[i]  = lo0 & 32'h03FF_FFFE;
    m_lo1[i]  = lo1 & 32'h03FF_FFFE;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) model_write(i, 0, 0, 0, 0);
  endfunction

  logic [31:0] e_ipa, e_dpa;
  logic [1:0]  e_ifl;
  logic [2:0]  e_dfl;

  // One clock: predict registered outputs from pre-edge state, then apply the write.
  task automatic tick();
    logic [31:0] pa, eh, pm, l0, l1;
    logic [2:0]  fl;
    logic        do_wr;
    int          widx;
    if (!stallF) begin
      model_xlat(inst_vaddr, entry_hi_W[7:0], 1'b0, pa, fl);
      e_ipa = pa;
      e_ifl = fl[2:1];
    end
    model_xlat(data_vaddr, entry_hi_W[7:0], data_store, e_dpa, e_dfl);
    do_wr = !rst && !stallM && (tlb_typeE[3] || tlb_typeE[2]);
    widx  = tlb_typeE[3] ? int'(random_o % 16) : int'(index_W % 16);
    eh = entry_hi_W; pm = page_mask_W; l0 = entry_lo0_W; l1 = entry_lo1_W;
    @(posedge clk);
    #1;
    if (rst) begin
      e_ipa = 0; e_ifl = 0; e_dpa = 0; e_dfl = 0;
`ifdef TLB_RESET_CLEAR_EN
      model_clear();
`endif
    end else if (do_wr) begin
      model_write(widx, eh, pm, l0, l1);
    end
  endtask

  task automatic drive(input logic [3:0] t, input logic [31:0] eh, input logic [31:0] pm,
                       input logic [31:0] lo0, input logic [31:0] lo1, input logic [31:0] idx);
    tlb_typeE = t; entry_hi_W = eh; page_mask_W = pm;
    entry_lo0_W = lo0; entry_lo1_W = lo1; index_W = idx;
  endtask

  task automatic check_read(input string name, input int i);
    check({name, ".hi"}, entry_hi_in, m_base[i] + 32'(m_asid[i]));
    check({name, ".pm"}, page_mask_in, m_big[i] ? 32'h6000 : 32'h0);
    check({name, ".lo0"}, entry_lo0_in, m_lo0[i] | 32'(m_g[i]));
    check({name, ".lo1"}, entry_lo1_in, m_lo1[i] | 32'(m_g[i]));
  endtask

  typedef struct {
    string       name;
    logic [3:0]  typ;
    logic [31:0] eh, pm, lo0, lo1, idx, dva;
    logic        st;
    logic [31:0] e_pa;
    logic [2:0]  e_fl;
    logic        chk_idx;
    logic [31:0] e_idx;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [3:0] t, input logic [31:0] eh,
                              input logic [31:0] pm, input logic [31:0] lo0,
                              input logic [31:0] lo1, input logic [31:0] idx,
                              input logic [31:0] dva, input logic st, input logic [31:0] epa,
                              input logic [2:0] efl, input logic ci, input logic [31:0] eidx);
    vec_t v;
    v.name = n; v.typ = t; v.eh = eh; v.pm = pm; v.lo0 = lo0; v.lo1 = lo1; v.idx = idx;
    v.dva = dva; v.st = st; v.e_pa = epa; v.e_fl = efl; v.chk_idx = ci; v.e_idx = eidx;
    return v;
  endfunction

  vec_t vecs [14];
  logic [31:0] pool [4];

  initial begin
    vecs[0]  = mk("wi3_same_edge",  T_WI,   32'h0040_0005, 0, 32'h486, 32'hD00, 3,
                  32'h0040_0010, 0, 0, 3'b100, 0, 0);
    vecs[1]  = mk("lw_hit",         T_NONE, 32'h0000_0005, 0, 0, 0, 0,
                  32'h0040_0010, 0, 32'h0001_2010, 3'b000, 0, 0);
    vecs[2]  = mk("asid_miss",      T_NONE, 32'h0000_0006, 0, 0, 0, 0,
                  32'h0040_0010, 0, 0, 3'b100, 0, 0);
    vecs[3]  = mk("wi3_global",     T_WI,   32'h0040_0005, 0, 32'h487, 32'hD01, 3,
                  32'h0040_0010, 0, 32'h0001_2010, 3'b000, 0, 0);
    vecs[4]  = mk("global_hit",     T_NONE, 32'h0000_0006, 0, 0, 0, 0,
                  32'h0040_0010, 0, 32'h0001_2010, 3'b000, 0, 0);
    vecs[5]  = mk("odd_invalid",    T_NONE, 32'h0000_0006, 0, 0, 0, 0,
                  32'h0040_1000, 0, 0, 3'b010, 0, 0);
    vecs[6]  = mk("wi3_clean_unmap", T_WI,  32'h0040_0005, 0, 32'h483, 32'hD01, 3,
                  32'h8000_1234, 1, 32'h0000_1234, 3'b000, 0, 0);
    vecs[7]  = mk("store_modify",   T_NONE, 32'h0000_0006, 0, 0, 0, 0,
                  32'h0040_0010, 1, 0, 3'b001, 0, 0);
    vecs[8]  = mk("load_clean",     T_NONE, 32'h0000_0006, 0, 0, 0, 0,
                  32'h0040_0010, 0, 32'h0001_2010, 3'b000, 0, 0);
    vecs[9]  = mk("tlbp_hit",       T_P,    32'h0040_0005, 0, 0, 0, 0,
                  32'h0040_0ABC, 0, 32'h0001_2ABC, 3'b000, 1, 32'h3);
    vecs[10] = mk("tlbp_miss",      T_P,    32'h1234_4005, 0, 0, 0, 0,
                  32'h1234_4000, 0, 0, 3'b100, 1, 32'h8000_0000);
    vecs[11] = mk("wi9_16k",        T_WI,   32'h00A0_6007, 32'h6000, 32'h1546, 32'h1DC2, 9,
                  32'h0000_0000, 0, 0, 3'b100, 0, 0);
    vecs[12] = mk("16k_odd",        T_NONE, 32'h0000_0007, 0, 0, 0, 0,
                  32'h00A0_5678, 0, 32'h0007_5678, 3'b000, 0, 0);
    vecs[13] = mk("16k_even",       T_NONE, 32'h0000_0007, 0, 0, 0, 0,
                  32'h00A0_2345, 0, 32'h0005_6345, 3'b000, 0, 0);
    pool[0] = 32'h0040_0000; pool[1] = 32'h0040_8000;
    pool[2] = 32'h1001_0000; pool[3] = 32'h7FFF_8000;

    model_clear();
    rst = 1; stallF = 0; stallM = 0; data_store = 0;
    inst_vaddr = 32'h8000_1000; data_vaddr = 32'h8000_1000; random_o = 0;
    drive(T_NONE, 0, 0, 0, 0, 0);
    repeat (2) tick();
    check("rst.inst_pa", inst_paddr, 0);
    check("rst.data_pa", data_paddr, 0);
    check("rst.flags", {27'b0, inst_tlb_refill, inst_tlb_invalid, data_tlb_refill,
                        data_tlb_invalid, data_tlb_modify}, 0);
    rst = 0;

    for (int i = 0; i < 16; i++) begin
      drive(T_WI, 32'h7000_0000 + 32'(i) * 32'h2000 + 32'hFF, 0, 0, 0, 32'(i));
      tick();
    end

    foreach (vecs[i]) begin
      drive(vecs[i].typ, vecs[i].eh, vecs[i].pm, vecs[i].lo0, vecs[i].lo1, vecs[i].idx);
      data_vaddr = vecs[i].dva; data_store = vecs[i].st;
      #1;
      if (vecs[i].chk_idx) check({vecs[i].name, ".index_in"}, index_in, vecs[i].e_idx);
      tick();
      check({vecs[i].name, ".flags"}, {29'b0, data_tlb_refill, data_tlb_invalid,
                                        data_tlb_modify}, {29'b0, vecs[i].e_fl});
      if (vecs[i].e_fl == 3'b000) check({vecs[i].name, ".pa"}, data_paddr, vecs[i].e_pa);
    end
    data_store = 0;

    // tlbr readback: G on both lo regs, then split G reads back as 0.
    drive(T_WI, 32'h0040_0005, 0, 32'h487, 32'hD01, 3); tick();
    drive(T_R, 32'h0000_0005, 0, 0, 0, 3); #1;
    check("tlbr.hi", entry_hi_in, 32'h0040_0005);
    check("tlbr.lo0", entry_lo0_in, 32'h487);
    check("tlbr.lo1", entry_lo1_in, 32'hD01);
    check("tlbr.pm", page_mask_in, 0);
    drive(T_WI, 32'h0040_0005, 0, 32'h487, 32'hD00, 3); tick();
    drive(T_R, 32'h0000_0005, 0, 0, 0, 3); #1;
    check("tlbr_gsplit.lo0", entry_lo0_in, 32'h486);
    drive(T_R, 32'h0000_0005, 0, 0, 0, 9); #1;
    check("tlbr16k.hi", entry_hi_in, 32'h00A0_0007);
    check("tlbr16k.pm", page_mask_in, 32'h6000);

    stallM = 1;
    drive(T_WI, 32'h1111_2005, 0, 32'h2, 32'h2, 3); tick();
    stallM = 0;
    drive(T_R, 32'h0000_0005, 0, 0, 0, 3); #1;
    check("stallM.hi", entry_hi_in, 32'h0040_0005);

    random_o = 32'hFFFF_FFFC;
    drive(T_WR | T_WI, 32'h2222_2003, 0, 32'h2, 32'h2, 3); tick();
    drive(T_R, 32'h0000_0005, 0, 0, 0, 12); #1;
    check("tlbwr.hi", entry_hi_in, 32'h2222_2003);
    drive(T_R, 32'h0000_0005, 0, 0, 0, 3); #1;
    check("tlbwr.keep3", entry_hi_in, 32'h0040_0005);

    drive(T_NONE, 32'h0000_0005, 0, 0, 0, 0);
    inst_vaddr = 32'hBFC0_0000; tick();
    check("inst_unmap.pa", inst_paddr, 32'h1FC0_0000);
    check("inst_unmap.fl", {30'b0, inst_tlb_refill, inst_tlb_invalid}, 0);
    stallF = 1; inst_vaddr = 32'h1234_0000; tick(); tick();
    check("stallF.hold", inst_paddr, 32'h1FC0_0000);
    stallF = 0; tick();
    check("inst_refill", {30'b0, inst_tlb_refill, inst_tlb_invalid}, 32'h2);
    inst_vaddr = 32'h0040_0010; tick();
    check("inst_hit.pa", inst_paddr, 32'h0001_2010);

    rst = 1;
    drive(T_WI, 32'h3333_3005, 0, 32'h2, 32'h2, 3); tick();
    rst = 0;
    check("rst_mid.data_pa", data_paddr, 0);
    check("rst_mid.inst_pa", inst_paddr, 0);
    drive(T_R, 32'h0000_0005, 0, 0, 0, 3); #1;
    check_read("rst_drop", 3);
    if (m_base[3] == 32'h3333_2000) check("rst_drop.model", 1, 0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] eh, va;
      int          k, r;
      k  = $urandom_range(0, 3);
      eh = pool[k] | ($urandom & 32'h6000) | 32'($urandom_range(1, 3));
      r  = $urandom_range(0, 7);
      case (r)
        3:       drive(T_WI, eh, 0, 0, 0, $urandom);
        4:       drive(T_WR, eh, 0, 0, 0, $urandom);
        5:       drive(T_P, eh, 0, 0, 0, $urandom);
        6:       drive(T_R, eh, 0, 0, 0, $urandom);
        7:       drive(T_WR | T_WI, eh, 0, 0, 0, $urandom);
        default: drive(T_NONE, eh, 0, 0, 0, $urandom);
      endcase
      page_mask_W = $urandom_range(0, 1) ? 32'h6000 : 32'h0;
      entry_lo0_W = $urandom; entry_lo1_W = $urandom; random_o = $urandom;
      stallM = ($urandom_range(0, 3) == 0);
      stallF = ($urandom_range(0, 3) == 0);
      data_store = $urandom_range(0, 1);
      for (int p = 0; p < 2; p++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      va = 32'h8000_0000 | ($urandom & 32'h3FFF_FFFF);
        else if (r == 1) va = $urandom;
        else             va = pool[$urandom_range(0, 3)] | ($urandom & 32'h7FFF);
        if (p == 0) inst_vaddr = va; else data_vaddr = va;
      end
      #1;
      if (tlb_typeE[0]) begin
        k = model_find(entry_hi_W & 32'hFFFF_E000, entry_hi_W[7:0]);
        check("rnd.tlbp", index_in, (k < 0) ? 32'h8000_0000 : 32'(k));
      end
      if (tlb_typeE[1]) check_read("rnd.tlbr", int'(index_W % 16));
      tick();
      check("rnd.dfl", {29'b0, data_tlb_refill, data_tlb_invalid, data_tlb_modify},
            {29'b0, e_dfl});
      if (e_dfl == 3'b000) check("rnd.dpa", data_paddr, e_dpa);
      check("rnd.ifl", {30'b0, inst_tlb_refill, inst_tlb_invalid}, {30'b0, e_ifl});
      if (e_ifl == 2'b00) check("rnd.ipa", inst_paddr, e_ipa);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
